uart_frame_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_frame_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constant helpers for the UART frame transmitter.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned calc_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the last count.
module uart_baud_tick #(
  parameter int unsigned DIV   = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter with valid/ready input and configurable frame format.
// Define UART_FRAME_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the serialiser.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CntW = calc_w(Div);
  localparam int unsigned IdxW = calc_w(DATA_W);

  logic [1:0] sync_q;
  logic       rst_n;

  // Assert asynchronously, release two edges after rstn_i rises.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_n = sync_q[1];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              restart, tick;
  logic              stop_last, slot;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;

  uart_baud_tick #(
    .DIV   (Div),
    .CNT_W (CntW)
  ) u_baud (
    .clk     (clk_i),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  assign stop_last = (stop_idx_q == 1'(STOP_BITS - 1));
  // The serialiser can take a new word when idle or in the final cycle of the last stop bit.
  assign slot = (state_q == StIdle) || ((state_q == StStop) && tick && stop_last);

`ifdef UART_FRAME_TX_FIFO_EN
  localparam int unsigned PtrW = calc_w(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              full, empty, push, pop, bypass, wr_en;

  assign full    = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign ready_o = rst_n && !full;
  assign push    = valid_i && ready_o;
  assign pop     = slot && !empty;
  // An empty FIFO with a free serialiser hands the word straight through.
  assign bypass  = slot && empty && push;
  assign wr_en   = push && !bypass;

  assign load_valid = pop || bypass;
  assign load_data  = pop ? mem_q[rd_ptr_q] : data_i;
  assign busy_o     = (state_q != StIdle) || !empty;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
`else
  assign ready_o    = rst_n && (state_q == StIdle);
  assign load_valid = valid_i && ready_o;
  assign load_data  = data_i;
  assign busy_o     = (state_q != StIdle);
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    restart    = 1'b0;

    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IdxW'(DATA_W - 1)) begin
            state_d    = (PARITY != PAR_NONE) ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_last) state_d = StIdle;
          else           stop_idx_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (slot && load_valid) begin
      state_d = StStart;
      shreg_d = load_data;
      par_d   = (PARITY == PAR_ODD) ? ~(^load_data) : ^load_data;
      restart = 1'b1;
    end
  end

  // Line level is registered from the next state so tx_o never glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: four frame formats side by side, back-to-back and reset cases.
module tb_uart_frame_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] d_a, d_e, d_o;
  logic [4:0] d_f;
  logic       valid_a, valid_e, valid_o, valid_f;
  logic       ready_a, ready_e, ready_o, ready_f;
  logic       tx_a, tx_e, tx_o, tx_f;
  logic       busy_a, busy_e, busy_o, busy_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_W(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_a (
    .clk_i(clk), .rstn_i(rstn), .data_i(d_a), .valid_i(valid_a), .ready_o(ready_a),
    .tx_o(tx_a), .busy_o(busy_a));

  uart_frame_tx #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_W(8), .PARITY(2), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_e (
    .clk_i(clk), .rstn_i(rstn), .data_i(d_e), .valid_i(valid_e), .ready_o(ready_e),
    .tx_o(tx_e), .busy_o(busy_e));

  uart_frame_tx #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_W(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_o (
    .clk_i(clk), .rstn_i(rstn), .data_i(d_o), .valid_i(valid_o), .ready_o(ready_o),
    .tx_o(tx_o), .busy_o(busy_o));

  uart_frame_tx #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_W(5), .PARITY(0), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_f (
    .clk_i(clk), .rstn_i(rstn), .data_i(d_f), .valid_i(valid_f), .ready_o(ready_f),
    .tx_o(tx_f), .busy_o(busy_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line bits in time order (index 0 = start bit); idle high past the frame.
  function automatic logic exp_bit(input logic [11:0] seq, input int len, input int n);
    if (n / 12 < len) return seq[n / 12];
    return 1'b1;
  endfunction

  task automatic wait_ready_a();
    int k;
    k = 0;
    while (ready_a !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_a_after_reset", 32'(ready_a), 32'd1);
  endtask

  logic [11:0] seq_a, seq_e, seq_o, seq_f, seq_55;
  logic [7:0]  words [6];
  int          idx;
  int          drop_seen;

  initial begin
    seq_a  = 12'b0011_0100_0110;  // 0xA3 8N1
    seq_e  = 12'b0101_0100_0110;  // 0xA3 8E1, parity 0
    seq_o  = 12'b0111_0100_0110;  // 0xA3 8O1, parity 1
    seq_f  = 12'b0000_1110_1010;  // 0x15 5N2
    seq_55 = 12'b0010_1010_1010;  // 0x55 8N1
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'hC5;
    words[3] = 8'h3C; words[4] = 8'hF0; words[5] = 8'h0F;
    d_a = '0; d_e = '0; d_o = '0; d_f = '0;
    valid_a = 1'b0; valid_e = 1'b0; valid_o = 1'b0; valid_f = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_tx_f", 32'(tx_f), 32'd1);
    chk("rst_ready_f", 32'(ready_f), 32'd0);

    rstn = 1'b1;
    @(negedge clk);
    wait_ready_a();
    chk("ready_e", 32'(ready_e), 32'd1);
    chk("ready_o", 32'(ready_o), 32'd1);
    chk("ready_f", 32'(ready_f), 32'd1);

    // Four formats launched on the same edge.
    d_a = 8'hA3; d_e = 8'hA3; d_o = 8'hA3; d_f = 5'h15;
    valid_a = 1'b1; valid_e = 1'b1; valid_o = 1'b1; valid_f = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; valid_e = 1'b0; valid_o = 1'b0; valid_f = 1'b0;
    for (int n = 0; n < 140; n++) begin
      chk($sformatf("8n1_tx@%0d", n), 32'(tx_a), 32'(exp_bit(seq_a, 10, n)));
      chk($sformatf("8e1_tx@%0d", n), 32'(tx_e), 32'(exp_bit(seq_e, 11, n)));
      chk($sformatf("8o1_tx@%0d", n), 32'(tx_o), 32'(exp_bit(seq_o, 11, n)));
      chk($sformatf("5n2_tx@%0d", n), 32'(tx_f), 32'(exp_bit(seq_f, 8, n)));
      chk($sformatf("8n1_busy@%0d", n), 32'(busy_a), 32'(n < 120));
      chk($sformatf("8e1_busy@%0d", n), 32'(busy_e), 32'(n < 132));
      chk($sformatf("5n2_busy@%0d", n), 32'(busy_f), 32'(n < 96));
`ifndef UART_FRAME_TX_FIFO_EN
      chk($sformatf("8n1_ready@%0d", n), 32'(ready_a), 32'(n >= 120));
`endif
      @(negedge clk);
    end

`ifndef UART_FRAME_TX_FIFO_EN
    // valid held high: second word only taken once idle, one idle cycle between frames.
    d_a = 8'hA3;
    valid_a = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 246; n++) begin
      logic e_tx;
      if (n < 120)       e_tx = exp_bit(seq_a, 10, n);
      else if (n == 120) e_tx = 1'b1;
      else               e_tx = exp_bit(seq_a, 10, n - 121);
      chk($sformatf("hold_tx@%0d", n), 32'(tx_a), 32'(e_tx));
      chk($sformatf("hold_busy@%0d", n), 32'(busy_a),
          32'((n < 120) || (n >= 121 && n < 241)));
      if (n <= 121) chk($sformatf("hold_ready@%0d", n), 32'(ready_a), 32'(n == 120));
      if (n == 121) valid_a = 1'b0;
      @(negedge clk);
    end
`else
    // Six words pushed as fast as ready allows; frames must follow each other gaplessly.
    idx = 0;
    drop_seen = 0;
    d_a = words[0];
    valid_a = 1'b1;
    idx = 1;
    @(negedge clk);
    for (int n = 0; n < 730; n++) begin
      logic e_tx;
      int f, k;
      f = n / 120;
      k = (n % 120) / 12;
      if (n >= 720)    e_tx = 1'b1;
      else if (k == 0) e_tx = 1'b0;
      else if (k == 9) e_tx = 1'b1;
      else             e_tx = words[f][k-1];
      chk($sformatf("fifo_tx@%0d", n), 32'(tx_a), 32'(e_tx));
      chk($sformatf("fifo_busy@%0d", n), 32'(busy_a), 32'(n < 720));
      if (!ready_a && drop_seen == 0) begin
        drop_seen = 1;
        chk("fifo_accepts_before_full", 32'(idx), 32'd5);
      end
      if (ready_a && idx < 6) begin
        d_a = words[idx];
        valid_a = 1'b1;
        idx++;
      end else begin
        valid_a = 1'b0;
      end
      @(negedge clk);
    end
    chk("fifo_full_seen", 32'(drop_seen), 32'd1);
    chk("fifo_all_pushed", 32'(idx), 32'd6);
`endif

    // Reset in the middle of the data bits, then a clean 0x55 frame.
    d_a = 8'hA3;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_tx_before_rst", 32'(tx_a), 32'(exp_bit(seq_a, 10, 40)));
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wait_ready_a();
    chk("post_rst_tx_idle", 32'(tx_a), 32'd1);
    d_a = 8'h55;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int n = 0; n < 130; n++) begin
      chk($sformatf("x55_tx@%0d", n), 32'(tx_a), 32'(exp_bit(seq_55, 10, n)));
      chk($sformatf("x55_busy@%0d", n), 32'(busy_a), 32'(n < 120));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
